vgroup_uop_sequencer: RTL

//  Sits directly upstream of the combinational LMUL grouping selector in the vector execute path.

---
 rtl/vgroup_uop_sequencer.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vgroup_uop_sequencer.sv
// Vector LMUL group micro-op sequencer: latches one decoded vector instruction and
// issues one micro-op per register of its group over a valid/ready handshake.
module vgroup_uop_sequencer #(
  parameter int unsigned OPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [OPW-1:0] in_op,
  input  logic [4:0]     in_raA,
  input  logic [4:0]     in_raB,
  input  logic [4:0]     in_rdest,
  input  logic [2:0]     in_lmul,
  output logic           uop_valid,
  input  logic           uop_ready,
  output logic [OPW-1:0] uop_op,
  output logic [4:0]     uop_raA,
  output logic [4:0]     uop_raB,
  output logic [4:0]     uop_rdest,
  output logic [2:0]     uop_idx,
  output logic           uop_last,
  output logic           stall_fetch,
  output logic           illegal
);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic [4:0]     ra_a_q, ra_a_d;
  logic [4:0]     ra_b_q, ra_b_d;
  logic [4:0]     rd_q, rd_d;
  logic [2:0]     last_idx_q, last_idx_d;
  logic [2:0]     idx_q, idx_d;
  logic           illegal_q, illegal_d;

  logic           lmul_ok;
  logic [2:0]     lmul_last;
  logic           in_legal;
  logic           is_last;

  // lmul_last doubles as the alignment mask for the base registers.
  always_comb begin
    lmul_ok   = 1'b1;
    lmul_last = 3'd0;
    case (in_lmul)
      3'b000:  lmul_last = 3'd0;
      3'b001:  lmul_last = 3'd1;
      3'b010:  lmul_last = 3'd3;
      3'b011:  lmul_last = 3'd7;
      default: lmul_ok   = 1'b0;
    endcase
  end

  assign in_legal = lmul_ok
                  && ((in_raA[2:0] & lmul_last) == 3'd0)
                  && ((in_raB[2:0] & lmul_last) == 3'd0)
                  && ((in_rdest[2:0] & lmul_last) == 3'd0);

  assign is_last = (idx_q == last_idx_q);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    ra_a_d     = ra_a_q;
    ra_b_d     = ra_b_q;
    rd_d       = rd_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    illegal_d  = 1'b0;
    if (flush) begin
      state_d = StIdle;
      idx_d   = 3'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (in_legal) begin
              state_d    = StIssue;
              op_d       = in_op;
              ra_a_d     = in_raA;
              ra_b_d     = in_raB;
              rd_d       = in_rdest;
              last_idx_d = lmul_last;
              idx_d      = 3'd0;
            end else begin
              illegal_d = 1'b1;
            end
          end
        end
        StIssue: begin
          if (uop_ready) begin
            if (is_last) begin
              state_d = StIdle;
              idx_d   = 3'd0;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      op_q       <= '0;
      ra_a_q     <= 5'd0;
      ra_b_q     <= 5'd0;
      rd_q       <= 5'd0;
      last_idx_q <= 3'd0;
      idx_q      <= 3'd0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      ra_a_q     <= ra_a_d;
      ra_b_q     <= ra_b_d;
      rd_q       <= rd_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      illegal_q  <= illegal_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign uop_valid   = (state_q == StIssue);
  assign uop_op      = op_q;
  assign uop_raA     = ra_a_q + {2'b00, idx_q};
  assign uop_raB     = ra_b_q + {2'b00, idx_q};
  assign uop_rdest   = rd_q + {2'b00, idx_q};
  assign uop_idx     = idx_q;
  // Gated so that uop_last reads 0 out of reset and between groups.
  assign uop_last    = uop_valid && is_last;
  assign stall_fetch = (state_q == StIssue) || (in_valid && !in_ready);
  assign illegal     = illegal_q;

endmodule
